data_mem_arbiter: RTL and testbench

- Shares the byte-addressed data memory between two 64-bit requesters: port 0 (core load/store) and port 1 (program/data loader or debug).
- Grants one requester at a time with round-robin fairness.
- Serialises each doubleword access into 8 byte-wide memory beats, little-endian: byte k of the word sits at address base+k.
- Sits between the core/loader and the data memory array; owns all memory address, write-enable and write-data lines.

---
 rtl/data_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter that shares a byte-wide data memory
// between two 64-bit requesters. Each doubleword access is serialised into
// BYTES little-endian beats (byte k at base+k, wrapping at the top of memory).
//
// Optional build macro DATA_MEM_ARBITER_ALIGN_CHECK_EN: when defined, a
// request whose addr[2:0] is non-zero is rejected without touching memory,
// answered one cycle after accept with reqN_err=1 and reqN_done=1.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; arbitration and ready are live
// XFER  | one memory beat per cycle, beat_cnt counts remaining beats
// DONE  | completion pulse on the served port, then back to IDLE
module data_mem_arbiter #(
    parameter int AW    = 6,
    parameter int BYTES = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req0_valid,
    input  logic                 req0_we,
    input  logic [AW-1:0]        req0_addr,
    input  logic [BYTES*8-1:0]   req0_wdata,
    output logic                 req0_ready,
    output logic                 req0_done,
    output logic [BYTES*8-1:0]   req0_rdata,
    output logic                 req0_err,
    input  logic                 req1_valid,
    input  logic                 req1_we,
    input  logic [AW-1:0]        req1_addr,
    input  logic [BYTES*8-1:0]   req1_wdata,
    output logic                 req1_ready,
    output logic                 req1_done,
    output logic [BYTES*8-1:0]   req1_rdata,
    output logic                 req1_err,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_we,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 busy
);
    localparam int DW = BYTES * 8;
    localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] BEAT_LOAD = CW'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   beat_cnt;
    logic            last_grant;
    logic            lat_we;
    logic            lat_port;
    logic [DW-1:0]   wshift;
    logic [DW-1:0]   rbuf;
    logic            grant0, grant1, accept, sel_port, sel_we, misalign;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    assign busy = (state != IDLE);

    // Round-robin grant: on a tie the port that did not win last time goes first.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        req0_ready = (state == IDLE) & ~RST & grant0;
        req1_ready = (state == IDLE) & ~RST & grant1;
        accept     = req0_ready | req1_ready;
        sel_port   = grant1;
        sel_we     = sel_port ? req1_we    : req0_we;
        sel_addr   = sel_port ? req1_addr  : req0_addr;
        sel_wdata  = sel_port ? req1_wdata : req0_wdata;
        misalign   = 1'b0;
`ifdef DATA_MEM_ARBITER_ALIGN_CHECK_EN
        misalign   = (sel_addr[2:0] != 3'd0);
`endif
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = misalign ? DONE : XFER;
            XFER:    if (beat_cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath: latch request, drive memory beats, assemble read word, pulse done.
    always_ff @(posedge CLK) begin
        if (RST) begin
            beat_cnt   <= '0;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_port   <= 1'b0;
            wshift     <= '0;
            rbuf       <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= 8'h00;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
        end else begin
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= sel_port;
                        lat_port   <= sel_port;
                        lat_we     <= sel_we;
                        beat_cnt   <= BEAT_LOAD;
                        if (misalign) begin
                            if (sel_port) begin
                                req1_done <= 1'b1;
                                req1_err  <= 1'b1;
                            end else begin
                                req0_done <= 1'b1;
                                req0_err  <= 1'b1;
                            end
                        end else begin
                            mem_addr  <= sel_addr;
                            mem_we    <= sel_we;
                            mem_wdata <= sel_we ? sel_wdata[7:0] : 8'h00;
                            wshift    <= sel_wdata >> 8;
                        end
                    end
                end
                XFER: begin
                    // Bytes shift in from the top so byte 0 ends up in the low lane.
                    rbuf <= {mem_rdata, rbuf[DW-1:8]};
                    if (beat_cnt == '0) begin
                        mem_we    <= 1'b0;
                        mem_wdata <= 8'h00;
                        if (lat_port) begin
                            req1_done  <= 1'b1;
                            req1_rdata <= lat_we ? '0 : {mem_rdata, rbuf[DW-1:8]};
                        end else begin
                            req0_done  <= 1'b1;
                            req0_rdata <= lat_we ? '0 : {mem_rdata, rbuf[DW-1:8]};
                        end
                    end else begin
                        beat_cnt  <= beat_cnt - CW'(1);
                        mem_addr  <= mem_addr + AW'(1);
                        mem_wdata <= lat_we ? wshift[7:0] : 8'h00;
                        wshift    <= wshift >> 8;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: byte memory model, reference
// memory plus scoreboard of expected completions (port, data, err, cycle).
module tb_data_mem_arbiter;
    localparam int AW    = 6;
    localparam int BYTES = 8;
    localparam int DW    = 64;
    localparam int MSZ   = 2**AW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req0_valid, req0_we, req0_ready, req0_done, req0_err;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic          req1_valid, req1_we, req1_ready, req1_done, req1_err;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          busy;

    data_mem_arbiter #(.AW(AW), .BYTES(BYTES)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_rdata(req1_rdata), .req1_err(req1_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 5);
    endfunction

    // Byte memory: combinational read, write on the rising edge.
    logic [7:0] mem [MSZ];
    logic [7:0] ref_mem [MSZ];
    assign mem_rdata = mem[mem_addr];
    always @(posedge CLK) begin
        if (cyc == 0) begin
            for (int i = 0; i < MSZ; i++) mem[i] <= init_byte(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    function automatic logic [63:0] peek(input logic [AW-1:0] a);
        logic [63:0] w;
        logic [AW-1:0] ak;
        w = '0;
        for (int k = 0; k < BYTES; k++) begin
            ak = a + AW'(k);
            w[8*k +: 8] = mem[ak];
        end
        return w;
    endfunction

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        bit          port;
        logic [63:0] rdata;
        bit          err;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   acc_port[$];
    int   acc_edge[$];
    int   we_cnt = 0;

    // Reference model: applied when the request is seen to be accepted.
    task automatic sb_push(input bit p);
        exp_t e;
        logic we;
        logic [AW-1:0] a, ak;
        logic [63:0] d;
        bit mis;
        we  = p ? req1_we    : req0_we;
        a   = p ? req1_addr  : req0_addr;
        d   = p ? req1_wdata : req0_wdata;
        mis = 1'b0;
`ifdef DATA_MEM_ARBITER_ALIGN_CHECK_EN
        mis = (a[2:0] != 3'd0);
`endif
        e.port  = p;
        e.err   = mis;
        e.rdata = '0;
        e.due   = cyc + 1 + (mis ? 0 : BYTES);
        if (!mis) begin
            for (int k = 0; k < BYTES; k++) begin
                ak = a + AW'(k);
                if (we) ref_mem[ak] = d[8*k +: 8];
                else    e.rdata[8*k +: 8] = ref_mem[ak];
            end
        end
        sb.push_back(e);
        acc_port.push_back(p);
        acc_edge.push_back(cyc + 1);
    endtask

    // Monitor: samples just after the falling edge, once inputs have settled.
    always @(negedge CLK) begin
        #2;
        if (RST) begin
            sb.delete();
        end else begin
            if (mem_we) we_cnt++;
            chk("we_outside_xfer", 64'(mem_we & ~busy), 64'd0);
            chk("err_without_done", 64'((req0_err & ~req0_done) | (req1_err & ~req1_done)), 64'd0);
            if (req0_done || req1_done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'({req1_done, req0_done}), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_port", 64'({req1_done, req0_done}), mon_e.port ? 64'd2 : 64'd1);
                    chk("rdata", mon_e.port ? req1_rdata : req0_rdata, mon_e.rdata);
                    chk("err", 64'(mon_e.port ? req1_err : req0_err), 64'(mon_e.err));
                    chk("done_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                chk("done_timeout", 64'(cyc), 64'(sb[0].due));
                void'(sb.pop_front());
            end
            if (req0_valid && req0_ready) sb_push(1'b0);
            if (req1_valid && req1_ready) sb_push(1'b1);
        end
    end

    task automatic issue(input bit p, input logic we, input logic [AW-1:0] a, input logic [63:0] d);
        bit ok;
        ok = 1'b0;
        @(negedge CLK);
        if (p) begin req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d; end
        else   begin req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d; end
        for (int i = 0; i < 40; i++) begin
            #2;
            if (p ? req1_ready : req0_ready) ok = 1'b1;
            @(negedge CLK);
            if (ok) break;
        end
        if (p) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
        chk(p ? "accept1" : "accept0", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            #3;
            if (sb.size() == 0 && !busy) begin ok = 1'b1; break; end
        end
        chk("idle_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_accepts(input int target);
        for (int i = 0; i < 120; i++) begin
            @(negedge CLK);
            #3;
            if (acc_port.size() >= target) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int          w0, n0, rel;
    logic [31:0] old_ref;

    initial begin
        for (int i = 0; i < MSZ; i++) ref_mem[i] = init_byte(i);
        RST = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;

        // 1: reset values with a pending request on port 0
        repeat (3) begin
            @(negedge CLK);
            #2;
            chk("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
            chk("rst_busy_we", 64'({busy, mem_we}), 64'd0);
            chk("rst_done_err", 64'({req1_done, req0_done, req1_err, req0_err}), 64'd0);
            chk("rst_rdata", req0_rdata | req1_rdata, 64'd0);
        end
        @(negedge CLK);
        RST = 1'b0;
        #2;
        chk("ready_after_rst", 64'(req0_ready), 64'd1);
        @(negedge CLK);
        req0_valid = 1'b0;
        wait_idle();

        // 2: port 0 write, port 1 read back
        w0 = we_cnt;
        issue(1'b0, 1'b1, 6'd8, 64'h1122334455667788);
        wait_idle();
        chk("write_beats", 64'(we_cnt - w0), 64'd8);
        chk("mem_after_write", peek(6'd8), 64'h1122334455667788);
        issue(1'b1, 1'b0, 6'd8, 64'h0);
        wait_idle();

        // 3: tie straight out of reset, then continuous alternation
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd16;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd24;
        rel = cyc;
        n0  = acc_port.size();
        wait_accepts(n0 + 4);
        @(negedge CLK);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("tie_first_edge", 64'(acc_edge[n0]), 64'(rel + 1));
        for (int k = 0; k < 4; k++) begin
            chk("tie_port", 64'(acc_port[n0 + k]), 64'(k % 2));
            if (k > 0) chk("tie_gap", 64'(acc_edge[n0 + k] - acc_edge[n0 + k - 1]), 64'd10);
        end
        wait_idle();

        // 4: write wrapping past the top of memory, then read it back
        issue(1'b1, 1'b1, 6'd60, 64'h0807060504030201);
        wait_idle();
        chk("wrap_hi", 64'({mem[63], mem[62], mem[61], mem[60]}), 64'h04030201);
        chk("wrap_lo", 64'({mem[3], mem[2], mem[1], mem[0]}), 64'h08070605);
        issue(1'b0, 1'b0, 6'd60, 64'h0);
        wait_idle();

        // 5: reset after four write beats
        old_ref = {ref_mem[23], ref_mem[22], ref_mem[21], ref_mem[20]};
        issue(1'b0, 1'b1, 6'd16, 64'hA8A7A6A5A4A3A2A1);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        #2;
        chk("abort_busy_we", 64'({busy, mem_we}), 64'd0);
        chk("abort_written", 64'({mem[19], mem[18], mem[17], mem[16]}), 64'hA4A3A2A1);
        chk("abort_untouched", 64'({mem[23], mem[22], mem[21], mem[20]}), 64'(old_ref));
        for (int k = 0; k < 4; k++) ref_mem[20 + k] = old_ref[8*k +: 8];
        @(negedge CLK);
        RST = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd16;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd32;
        n0 = acc_port.size();
        wait_accepts(n0 + 1);
        @(negedge CLK);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("abort_next_grant", 64'(acc_port[n0]), 64'd0);
        wait_idle();

        // 6: misaligned read on port 1
        w0 = we_cnt;
        issue(1'b1, 1'b0, 6'd3, 64'h0);
        wait_idle();
        chk("misaligned_no_we", 64'(we_cnt - w0), 64'd0);

        for (int i = 0; i < MSZ; i++) chk("mem_final", 64'(mem[i]), 64'(ref_mem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
